// File: rtl/bip_control.sv
// bip_control: multi-cycle control unit for the BIP 16-bit accumulator core.
//
// Fetches an instruction (opcode IR[15:11], operand IR[10:0]), decodes it in one
// cycle, and runs one data-memory access for STO/LD/ADD/SUB. It also drives the
// ALU/accumulator control for the datapath.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   instr_req_o/addr_o/ack_i/data_i   program-memory fetch handshake
//   data_rd_o/wr_o/addr_o/ack_i  data-memory access handshake
//   alu_op_o, sel_b_o, imm_o     ALU op (1=ADD), B source (1=imm), sign-extended imm
//   acc_sel_o, acc_wr_o          accumulator source (1=load value) and write strobe
//   halted_o, illegal_o          core halted, illegal opcode trapped
//
// Build option: define BIP_ILLEGAL_TRAP_EN to halt on an illegal opcode and
// raise illegal_o. Otherwise illegal opcodes execute as NOPs.
module bip_control #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_ack_i,
  input  logic [DATA_W-1:0] instr_data_i,
  output logic              data_rd_o,
  output logic              data_wr_o,
  output logic [ADDR_W-1:0] data_addr_o,
  input  logic              data_ack_i,
  output logic              alu_op_o,
  output logic              sel_b_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              acc_sel_o,
  output logic              acc_wr_o,
  output logic              halted_o,
  output logic              illegal_o
);

  localparam logic [4:0] OpHlt  = 5'b00000;
  localparam logic [4:0] OpSto  = 5'b00001;
  localparam logic [4:0] OpLd   = 5'b00010;
  localparam logic [4:0] OpLdi  = 5'b00011;
  localparam logic [4:0] OpAdd  = 5'b00100;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpSub  = 5'b00110;
  localparam logic [4:0] OpSubi = 5'b00111;

  typedef enum logic [1:0] {StFetch, StDecode, StMem, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [4:0] opcode;
  logic       is_imm_op;
  logic       is_mem_op;

  assign opcode    = ir_q[DATA_W-1:ADDR_W];
  assign is_imm_op = (opcode == OpLdi) || (opcode == OpAddi) || (opcode == OpSubi);
  assign is_mem_op = (opcode == OpSto) || (opcode == OpLd) || (opcode == OpAdd) ||
                     (opcode == OpSub);

`ifdef BIP_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
`ifdef BIP_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef BIP_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef BIP_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (instr_ack_i) begin
          ir_d    = instr_data_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_imm_op) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StFetch;
        end else if (is_mem_op) begin
          state_d = StMem;
        end else if (opcode == OpHlt) begin
          state_d = StHalt;
        end else begin
`ifdef BIP_ILLEGAL_TRAP_EN
          // Trap: PC stays on the offending instruction.
          illegal_d = 1'b1;
          state_d   = StHalt;
`else
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StFetch;
`endif
        end
      end
      StMem: begin
        if (data_ack_i) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Output logic. Requests and strobes are masked during reset so that the
  // reset value of the state (StFetch) does not raise a fetch before release.
  always_comb begin
    instr_req_o = 1'b0;
    data_rd_o   = 1'b0;
    data_wr_o   = 1'b0;
    acc_wr_o    = 1'b0;
    halted_o    = 1'b0;
    unique case (state_q)
      StFetch:  instr_req_o = !rst_i;
      StDecode: acc_wr_o    = !rst_i && is_imm_op;
      StMem: begin
        data_wr_o = !rst_i && (opcode == OpSto);
        data_rd_o = !rst_i && (opcode != OpSto);
        acc_wr_o  = !rst_i && data_ack_i && (opcode != OpSto);
      end
      StHalt:   halted_o    = !rst_i;
      default: ;
    endcase
  end

  assign instr_addr_o = pc_q;
  assign data_addr_o  = ir_q[ADDR_W-1:0];
  assign alu_op_o     = (opcode == OpAdd) || (opcode == OpAddi);
  assign sel_b_o      = is_imm_op;
  assign acc_sel_o    = (opcode == OpLd) || (opcode == OpLdi);
  assign imm_o        = {{(DATA_W - ADDR_W){ir_q[ADDR_W-1]}}, ir_q[ADDR_W-1:0]};

`ifdef BIP_ILLEGAL_TRAP_EN
  assign illegal_o = illegal_q && !rst_i;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Directed self-checking bench for bip_control. Inputs change just after the
// falling edge; outputs are checked 1 time unit later, well clear of the rising edge.
module tb_bip_control;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_o;
  logic [10:0] instr_addr_o;
  logic        instr_ack_i;
  logic [15:0] instr_data_i;
  logic        data_rd_o;
  logic        data_wr_o;
  logic [10:0] data_addr_o;
  logic        data_ack_i;
  logic        alu_op_o;
  logic        sel_b_o;
  logic [15:0] imm_o;
  logic        acc_sel_o;
  logic        acc_wr_o;
  logic        halted_o;
  logic        illegal_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  bip_control dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .instr_req_o (instr_req_o),
    .instr_addr_o(instr_addr_o),
    .instr_ack_i (instr_ack_i),
    .instr_data_i(instr_data_i),
    .data_rd_o   (data_rd_o),
    .data_wr_o   (data_wr_o),
    .data_addr_o (data_addr_o),
    .data_ack_i  (data_ack_i),
    .alu_op_o    (alu_op_o),
    .sel_b_o     (sel_b_o),
    .imm_o       (imm_o),
    .acc_sel_o   (acc_sel_o),
    .acc_wr_o    (acc_wr_o),
    .halted_o    (halted_o),
    .illegal_o   (illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 unit after the falling edge.
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  // Expect a fetch at addr, answer with a zero-wait ack; returns in DECODE.
  task automatic fetch(input logic [10:0] addr, input logic [15:0] instr);
    check("fetch_req", instr_req_o, 1'b1);
    check("fetch_addr", instr_addr_o, addr);
    instr_ack_i  = 1'b1;
    instr_data_i = instr;
    step();
    instr_ack_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_i        = 1'b1;
    instr_ack_i  = 1'b0;
    instr_data_i = 16'h0000;
    data_ack_i   = 1'b0;
    #1;
    check("rst_req", instr_req_o, 1'b0);
    check("rst_rd", data_rd_o, 1'b0);
    check("rst_wr", data_wr_o, 1'b0);
    check("rst_accwr", acc_wr_o, 1'b0);
    check("rst_halted", halted_o, 1'b0);
    check("rst_illegal", illegal_o, 1'b0);
    step();
    rst_i = 1'b0;
    #1;

    // LDI 5 at PC 0
    fetch(11'd0, 16'h1805);
    check("ldi_accwr", acc_wr_o, 1'b1);
    check("ldi_accsel", acc_sel_o, 1'b1);
    check("ldi_selb", sel_b_o, 1'b1);
    check("ldi_imm", imm_o, 16'h0005);
    check("ldi_noreq", instr_req_o, 1'b0);
    step();

    // ADD 0x010 at PC 1, ack delayed 3 cycles
    fetch(11'd1, 16'h2010);
    check("add_dec_accwr", acc_wr_o, 1'b0);
    check("add_aluop", alu_op_o, 1'b1);
    check("add_selb", sel_b_o, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("add_wait_rd", data_rd_o, 1'b1);
      check("add_wait_addr", data_addr_o, 11'h010);
      check("add_wait_accwr", acc_wr_o, 1'b0);
      check("add_wait_noreq", instr_req_o, 1'b0);
      step();
    end
    data_ack_i = 1'b1;
    #1;
    check("add_ack_rd", data_rd_o, 1'b1);
    check("add_ack_accwr", acc_wr_o, 1'b1);
    check("add_ack_accsel", acc_sel_o, 1'b0);
    step();
    data_ack_i = 1'b0;
    #1;
    check("add_after_accwr", acc_wr_o, 1'b0);

    // SUBI 0x7FF at PC 2
    fetch(11'd2, 16'h3FFF);
    check("subi_imm", imm_o, 16'hFFFF);
    check("subi_aluop", alu_op_o, 1'b0);
    check("subi_selb", sel_b_o, 1'b1);
    check("subi_accwr", acc_wr_o, 1'b1);
    step();

    // STO 0x020 at PC 3, zero-wait ack
    fetch(11'd3, 16'h0820);
    check("sto_dec_accwr", acc_wr_o, 1'b0);
    step();
    data_ack_i = 1'b1;
    #1;
    check("sto_wr", data_wr_o, 1'b1);
    check("sto_rd", data_rd_o, 1'b0);
    check("sto_addr", data_addr_o, 11'h020);
    check("sto_accwr", acc_wr_o, 1'b0);
    check("sto_noreq", instr_req_o, 1'b0);
    step();
    data_ack_i = 1'b0;
    #1;

    // LDI 0x3FF at PC 4 (positive immediate), then filler LDIs at 5, 6
    fetch(11'd4, 16'h1BFF);
    check("ldi3ff_imm", imm_o, 16'h03FF);
    step();
    fetch(11'd5, 16'h1801);
    step();
    fetch(11'd6, 16'h1801);
    step();

    // Illegal opcode 11111 at PC 7
    fetch(11'd7, 16'hF800);
    check("ill_dec_accwr", acc_wr_o, 1'b0);
    step();
`ifdef BIP_ILLEGAL_TRAP_EN
    check("ill_halted", halted_o, 1'b1);
    check("ill_flag", illegal_o, 1'b1);
    check("ill_noreq", instr_req_o, 1'b0);
`else
    check("ill_flag", illegal_o, 1'b0);
    // HLT at PC 8
    fetch(11'd8, 16'h0000);
    step();
`endif
    for (int i = 0; i < 20; i++) begin
      check("hlt_halted", halted_o, 1'b1);
      check("hlt_noreq", instr_req_o, 1'b0);
      step();
    end
    rst_i = 1'b1;
    #1;
    check("hlt_rst_halted", halted_o, 1'b0);
    check("hlt_rst_illegal", illegal_o, 1'b0);
    step();
    rst_i = 1'b0;
    #1;
    check("restart_req", instr_req_o, 1'b1);
    check("restart_addr", instr_addr_o, 11'd0);

    // Run LDIs up to PC 2047, then wrap
    for (int i = 0; i < 2047; i++) begin
      fetch(11'(i), 16'h1800);
      step();
    end
    fetch(11'd2047, 16'h1800);
    check("wrap_accwr", acc_wr_o, 1'b1);
    step();
    check("wrap_addr", instr_addr_o, 11'd0);

    // LDI at 0, then LD 0x010 at 1 interrupted by reset during the MEM wait
    fetch(11'd0, 16'h1801);
    step();
    fetch(11'd1, 16'h1010);
    step();
    check("ld_wait_rd", data_rd_o, 1'b1);
    step();
    rst_i      = 1'b1;
    data_ack_i = 1'b1;
    #1;
    check("mrst_rd", data_rd_o, 1'b0);
    check("mrst_wr", data_wr_o, 1'b0);
    check("mrst_accwr", acc_wr_o, 1'b0);
    check("mrst_req", instr_req_o, 1'b0);
    check("mrst_halted", halted_o, 1'b0);
    step();
    check("mrst_hold_accwr", acc_wr_o, 1'b0);
    rst_i      = 1'b0;
    data_ack_i = 1'b0;
    #1;
    check("mrst_fetch_req", instr_req_o, 1'b1);
    check("mrst_fetch_addr", instr_addr_o, 11'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Multi-cycle control unit for the BIP 16-bit accumulator processor.
- Fetches 16-bit instructions from program memory and decodes them.
- Sequences data-memory reads and writes over ready/ack handshakes.
- Drives the ALU operation select (1 = ADD, 0 = SUB), the operand-B source, the sign-extended immediate and the accumulator write strobes. This makes it the initiator/sequencer that issues work to the ALU datapath.

Parameters:
- ADDR_W, 11, width of the program counter, instruction address and data address. Equals the instruction operand field width.
- DATA_W, 16, instruction and data word width. The immediate is sign-extended to this width.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- instr_req_o  out  1  program-memory fetch request
- instr_addr_o  out  ADDR_W  fetch address (current PC)
- instr_ack_i  in  1  fetch complete; instr_data_i valid this cycle
- instr_data_i  in  DATA_W  instruction word: [15:11] opcode, [10:0] operand
- data_rd_o  out  1  data-memory read request
- data_wr_o  out  1  data-memory write request (accumulator is stored)
- data_addr_o  out  ADDR_W  data address = IR operand
- data_ack_i  in  1  data access complete; read data valid this cycle
- alu_op_o  out  1  1 = ADD, 0 = SUB
- sel_b_o  out  1  ALU B source: 0 = memory data, 1 = immediate
- imm_o  out  DATA_W  sign-extended IR[10:0]
- acc_sel_o  out  1  accumulator input: 0 = ALU result, 1 = load value (memory or immediate per sel_b_o)
- acc_wr_o  out  1  accumulator write strobe, one cycle
- halted_o  out  1  core halted
- illegal_o  out  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Opcodes:
  - 00000 HLT
  - 00001 STO
  - 00010 LD
  - 00011 LDI
  - 00100 ADD
  - 00101 ADDI
  - 00110 SUB
  - 00111 SUBI
  - All other opcodes are illegal.
- Reset (asynchronous, any state):
  - State = FETCH, PC = 0, IR = 0.
  - All request and strobe outputs are 0; halted_o = 0, illegal_o = 0.
  - First request is issued in the first cycle after rst_i deasserts.
  - Reset during a pending handshake abandons it; no acc_wr_o pulse.
- States:
  - FETCH:
    - instr_req_o = 1, instr_addr_o = PC, held until instr_ack_i.
    - Zero-wait ack (ack in the same cycle as the request) is legal.
    - On ack: IR <= instr_data_i; go to DECODE.
  - DECODE (exactly 1 cycle):
    - LDI / ADDI / SUBI: acc_wr_o = 1 this cycle; PC <= PC+1; go to FETCH.
    - STO / LD / ADD / SUB: go to MEM.
    - HLT: go to HALT.
    - Illegal opcode: treated as NOP; PC <= PC+1; go to FETCH.
  - MEM:
    - data_addr_o = IR[10:0].
    - STO: data_wr_o = 1. LD / ADD / SUB: data_rd_o = 1.
    - The request is held until data_ack_i.
    - On ack for LD / ADD / SUB: acc_wr_o = 1 in the ack cycle.
    - On ack, all memory opcodes: PC <= PC+1; go to FETCH.
  - HALT:
    - halted_o = 1; no requests issued; state held until reset.
- Datapath control outputs:
  - Driven combinationally from IR, valid in DECODE and MEM.
  - alu_op_o = 1 for ADD / ADDI, else 0.
  - sel_b_o = 1 for LDI / ADDI / SUBI.
  - acc_sel_o = 1 for LD / LDI.
  - imm_o = IR[10:0] sign-extended (0x7FF → 0xFFFF; 0x3FF → 0x03FF).
- PC wraps modulo 2^ADDR_W (2047 + 1 → 0).
- instr_req_o and data_rd_o / data_wr_o are never asserted together.
- acc_wr_o is never asserted outside DECODE or a MEM ack cycle.
- Minimum latency:
  - Immediate instruction: 2 cycles (FETCH + DECODE).
  - Memory instruction: 3 cycles (FETCH + DECODE + MEM).
- Wait cycles on an ack add 1 cycle each.

Optional Feature:
- Macro: BIP_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE goes to HALT instead of acting as a NOP.
  - PC is not incremented.
  - illegal_o = 1 and halted_o = 1, both sticky until reset.
- Undefined:
  - Illegal opcodes are NOPs.
  - illegal_o is tied to 0.

Test Plan:
- Reset, then LDI 5 (0x1805) with zero-wait acks → instr_addr_o = 0; acc_wr_o pulses in cycle 2 with acc_sel_o = 1, sel_b_o = 1, imm_o = 0x0005; next fetch at address 1.
- ADD 0x010 (0x2010) with data_ack_i delayed 3 cycles → data_rd_o high for 4 cycles at data_addr_o = 0x010; alu_op_o = 1; single acc_wr_o pulse in the ack cycle.
- SUBI 0x7FF (0x3FFF) → imm_o = 0xFFFF, alu_op_o = 0, sel_b_o = 1, acc_wr_o in DECODE; STO 0x020 (0x0820) → data_wr_o = 1, no acc_wr_o.
- HLT (0x0000) → halted_o = 1; instr_req_o stays 0 for 20 cycles; rst_i pulse → fetch restarts at address 0.
- Opcode 11111 at PC 7 → without the macro: NOP, next fetch at 8; with BIP_ILLEGAL_TRAP_EN: halted_o = illegal_o = 1, no further fetch.
- PC at 2047 executing LDI, plus a separate case with rst_i asserted mid-MEM wait → next fetch at address 0 in both; the reset case shows no acc_wr_o pulse and all outputs cleared immediately.
